// File: rtl/vram_pkg.sv
// Shared widths and grant encoding for the video RAM port arbiter.
package vram_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 18;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_DISP = 2'd1;
  localparam gnt_t GNT_WA   = 2'd2;
  localparam gnt_t GNT_WB   = 2'd3;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Request/response and BSRAM bus bundle between the LCD fetcher, the two writers and the video RAM.
interface vram_port_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ready;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              wa_valid;
  logic              wa_ready;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // The arbiter is the slave of the requesters and drives the memory.
  modport slave (
    input  disp_valid, disp_addr, wa_valid, wa_addr, wa_data, wb_valid, wb_addr, wb_data, mem_dout,
    output disp_ready, disp_rvalid, disp_rdata, wa_ready, wb_ready, mem_ce, mem_wre, mem_ad, mem_din
  );

  modport master (
    output disp_valid, disp_addr, wa_valid, wa_addr, wa_data, wb_valid, wb_addr, wb_data, mem_dout,
    input  disp_ready, disp_rvalid, disp_rdata, wa_ready, wb_ready, mem_ce, mem_wre, mem_ad, mem_din
  );

endinterface

// File: rtl/vram_rr_pick.sv
// Two-way round-robin picker; the pointer moves away from whichever writer was just served.
module vram_rr_pick (
  input  logic pixel_clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prefer_b;

  assign gnt_a = en && req_a && (!req_b || !prefer_b);
  assign gnt_b = en && req_b && (!req_a ||  prefer_b);

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      prefer_b <= 1'b0;
    end else if (gnt_a) begin
      prefer_b <= 1'b1;
    end else if (gnt_b) begin
      prefer_b <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port video RAM arbiter: capped-priority display reads, round-robin writers, tagged read return.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int DISP_BURST = 8
) (
  input  logic               pixel_clk,
  input  logic               rst,
  vram_port_arbiter_if.slave bus,
  output logic               starve
);

  localparam int BURST_W    = $clog2(DISP_BURST + 1);
  localparam int WAIT_LIMIT = 4 * DISP_BURST;
  localparam int WAIT_W     = $clog2(WAIT_LIMIT + 2);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == {WAIT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [BURST_W-1:0] burst_cnt;
  logic               cap_hit;
  logic               disp_go;
  logic               gnt_a;
  logic               gnt_b;
  gnt_t               gnt;

  // The display only yields once its burst is used up and a writer is actually waiting.
  assign cap_hit = (burst_cnt == BURST_W'(DISP_BURST)) && (bus.wa_valid || bus.wb_valid);
  assign disp_go = bus.disp_valid && !cap_hit;

  vram_rr_pick u_rr (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .en        (!disp_go),
    .req_a     (bus.wa_valid),
    .req_b     (bus.wb_valid),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (disp_go) begin
      gnt = GNT_DISP;
    end else if (gnt_a) begin
      gnt = GNT_WA;
    end else if (gnt_b) begin
      gnt = GNT_WB;
    end
  end

  assign bus.disp_ready = disp_go;
  assign bus.wa_ready   = gnt_a;
  assign bus.wb_ready   = gnt_b;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (!disp_go) begin
      burst_cnt <= '0;
    end else if (burst_cnt != BURST_W'(DISP_BURST)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // ---- p0: issue register, the granted access drives the BSRAM one cycle after the handshake
  logic              ce_p0;
  logic              wre_p0;
  logic [ADDR_W-1:0] ad_p0;
  logic [DATA_W-1:0] din_p0;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      ce_p0  <= 1'b0;
      wre_p0 <= 1'b0;
      ad_p0  <= '0;
      din_p0 <= '0;
    end else begin
      ce_p0  <= (gnt != GNT_NONE);
      wre_p0 <= (gnt == GNT_WA) || (gnt == GNT_WB);
      case (gnt)
        GNT_DISP: ad_p0 <= bus.disp_addr;
        GNT_WA: begin
          ad_p0  <= bus.wa_addr;
          din_p0 <= bus.wa_data;
        end
        GNT_WB: begin
          ad_p0  <= bus.wb_addr;
          din_p0 <= bus.wb_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ce  = ce_p0;
  assign bus.mem_wre = wre_p0;
  assign bus.mem_ad  = ad_p0;
  assign bus.mem_din = din_p0;

  // ---- p1..: read tag pipe, the last stage captures mem_dout into the return register
  logic [RD_LAT-1:0] vld_p;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      vld_p    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      vld_p[0] <= disp_go;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      rvalid_q <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) begin
        rdata_q <= bus.mem_dout;
      end
    end
  end

  assign bus.disp_rvalid = rvalid_q;
  assign bus.disp_rdata  = rdata_q;

  logic [WAIT_W-1:0] wa_wait;
  logic [WAIT_W-1:0] wb_wait;
  logic              wa_stall;
  logic              wb_stall;

  assign wa_stall = bus.wa_valid && !gnt_a;
  assign wb_stall = bus.wb_valid && !gnt_b;

  // A stalled cycle with WAIT_LIMIT cycles already counted is the one that exceeds the limit.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      wa_wait <= '0;
      wb_wait <= '0;
      starve  <= 1'b0;
    end else begin
      wa_wait <= wa_stall ? sat_inc(wa_wait) : '0;
      wb_wait <= wb_stall ? sat_inc(wb_wait) : '0;
      if ((wa_stall && (wa_wait >= WAIT_W'(WAIT_LIMIT))) ||
          (wb_stall && (wb_wait >= WAIT_W'(WAIT_LIMIT)))) begin
        starve <= 1'b1;
      end
    end
  end

endmodule
